dp_sequencer: RTL

Multi-cycle sequencer for data-processing instructions in the CPU core. Accepts one decoded instruction over a valid/ready handshake and evaluates its condition code against the NZCV flags. It then reads operands from an internal register bank, drives the combinational ALU for one cycle, and writes back the result and/or flags. Sits between the decoder and the ALU; owns the general-purpose register bank and the NZCV flags.

---
 rtl/dp_sequencer_if.sv | 70 +++++++
 rtl/dp_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dp_sequencer_if.sv
// Bundle of the decoder handshake, ALU drive/return, completion, debug read
// and host preload signals of the data-processing sequencer.
interface dp_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    // Decoded instruction handshake
    logic                  instr_valid;
    logic                  instr_ready;
    logic [3:0]            instr_cond;
    logic [3:0]            instr_opcode;
    logic                  instr_s;
    logic [3:0]            instr_rn;
    logic [3:0]            instr_rd;
    logic [3:0]            instr_rm;
    logic                  instr_imm_sel;
    logic [DATA_WIDTH-1:0] instr_imm;

    // Combinational ALU drive and return
    logic                  alu_enable;
    logic [3:0]            alu_opcode;
    logic [DATA_WIDTH-1:0] alu_operand1;
    logic [DATA_WIDTH-1:0] alu_operand2;
    logic                  alu_carry_in;
    logic                  alu_flag_update;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_n;
    logic                  alu_z;
    logic                  alu_c;
    logic                  alu_v;

    // Completion and architectural flags
    logic                  done_valid;
    logic                  done_executed;
    logic [3:0]            nzcv;

    // Debug read and host preload
    logic [3:0]            dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_data;
    logic                  host_wr_en;
    logic [3:0]            host_wr_addr;
    logic [DATA_WIDTH-1:0] host_wr_data;

    // Sequencer side
    modport slave (
        input  instr_valid, instr_cond, instr_opcode, instr_s,
               instr_rn, instr_rd, instr_rm, instr_imm_sel, instr_imm,
        output instr_ready,
        output alu_enable, alu_opcode, alu_operand1, alu_operand2,
               alu_carry_in, alu_flag_update,
        input  alu_result, alu_n, alu_z, alu_c, alu_v,
        output done_valid, done_executed, nzcv,
        input  dbg_addr,
        output dbg_data,
        input  host_wr_en, host_wr_addr, host_wr_data
    );

    // Decoder / ALU / host side
    modport master (
        output instr_valid, instr_cond, instr_opcode, instr_s,
               instr_rn, instr_rd, instr_rm, instr_imm_sel, instr_imm,
        input  instr_ready,
        input  alu_enable, alu_opcode, alu_operand1, alu_operand2,
               alu_carry_in, alu_flag_update,
        output alu_result, alu_n, alu_z, alu_c, alu_v,
        input  done_valid, done_executed, nzcv,
        output dbg_addr,
        input  dbg_data,
        output host_wr_en, host_wr_addr, host_wr_data
    );
endinterface

// File: rtl/dp_sequencer.sv
// Multi-cycle sequencer for data-processing instructions: accepts one decoded
// instruction, checks its condition against NZCV, reads operands from the
// register bank, drives the external ALU for one cycle and writes back the
// result and/or flags.
module dp_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    dp_sequencer_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_READ = 2'b01;
    localparam logic [1:0] S_EXEC = 2'b10;
    localparam logic [1:0] S_WB   = 2'b11;

    // ARM condition-code evaluation against flags {N,Z,C,V}; 1111 never passes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v, pass;
        {n, z, c, v} = flags;
        case (cond)
            4'b0000: pass = z;
            4'b0001: pass = ~z;
            4'b0010: pass = c;
            4'b0011: pass = ~c;
            4'b0100: pass = n;
            4'b0101: pass = ~n;
            4'b0110: pass = v;
            4'b0111: pass = ~v;
            4'b1000: pass = c & ~z;
            4'b1001: pass = ~c | z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = ~z & (n == v);
            4'b1101: pass = z | (n != v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    // Opcodes whose V output is meaningful; logical ops keep the old V.
    function automatic logic is_arith(input logic [3:0] op);
        logic arith;
        case (op)
            4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1010, 4'b1011: arith = 1'b1;
            default:                           arith = 1'b0;
        endcase
        return arith;
    endfunction

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    logic [3:0]            r_cond;
    logic [3:0]            r_opcode;
    logic                  r_s;
    logic [3:0]            r_rn;
    logic [3:0]            r_rd;
    logic [3:0]            r_rm;
    logic                  r_imm_sel;
    logic [DATA_WIDTH-1:0] r_imm;

    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_op2;
    logic [DATA_WIDTH-1:0] r_result;
    logic [3:0]            r_alu_flags;
    logic [3:0]            r_nzcv;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  r_instr_ready;
    logic                  r_alu_enable;
    logic [3:0]            r_alu_opcode;
    logic                  r_alu_carry_in;
    logic                  r_alu_flag_update;
    logic                  r_done_valid;
    logic                  r_done_executed;

    logic                  w_accept;
    logic                  w_cond_pass;
    logic                  w_is_compare;
    logic                  w_flag_update;
    logic                  w_rd_write;
    logic                  w_flag_write;

    // r_instr_ready mirrors "state is IDLE", so it doubles as the accept gate.
    assign w_accept      = bus.instr_valid & r_instr_ready;
    assign w_cond_pass   = cond_pass(r_cond, r_nzcv);
    assign w_is_compare  = (r_opcode[3:2] == 2'b10);
    assign w_flag_update = r_s | w_is_compare;
    // r_done_executed is only set in WB when the instruction went through EXEC.
    assign w_rd_write    = (r_state == S_WB) & r_done_executed & ~w_is_compare;
    assign w_flag_write  = (r_state == S_WB) & r_done_executed & w_flag_update;

    // Next-state selection for the IDLE -> READ -> (EXEC) -> WB sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                if (w_cond_pass) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_EXEC:  w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch every instruction field at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cond    <= 4'b0000;
            r_opcode  <= 4'b0000;
            r_s       <= 1'b0;
            r_rn      <= 4'b0000;
            r_rd      <= 4'b0000;
            r_rm      <= 4'b0000;
            r_imm_sel <= 1'b0;
            r_imm     <= {DATA_WIDTH{1'b0}};
        end else if (w_accept) begin
            r_cond    <= bus.instr_cond;
            r_opcode  <= bus.instr_opcode;
            r_s       <= bus.instr_s;
            r_rn      <= bus.instr_rn;
            r_rd      <= bus.instr_rd;
            r_rm      <= bus.instr_rm;
            r_imm_sel <= bus.instr_imm_sel;
            r_imm     <= bus.instr_imm;
        end
    end

    // Fetch operands from the bank in READ; they stay held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op1 <= {DATA_WIDTH{1'b0}};
            r_op2 <= {DATA_WIDTH{1'b0}};
        end else if (r_state == S_READ) begin
            r_op1 <= r_regs[r_rn];
            r_op2 <= r_imm_sel ? r_imm : r_regs[r_rm];
        end
    end

    // Capture the ALU result and flags at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= {DATA_WIDTH{1'b0}};
            r_alu_flags <= 4'b0000;
        end else if (r_state == S_EXEC) begin
            r_result    <= bus.alu_result;
            r_alu_flags <= {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
        end
    end

    // Register bank: host preload first, so a same-edge writeback to the same index wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (bus.host_wr_en) begin
                r_regs[bus.host_wr_addr] <= bus.host_wr_data;
            end
            if (w_rd_write) begin
                r_regs[r_rd] <= r_result;
            end
        end
    end

    // NZCV update in WB; V only changes for arithmetic opcodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nzcv <= 4'b0000;
        end else if (w_flag_write) begin
            r_nzcv[3:1] <= r_alu_flags[3:1];
            if (is_arith(r_opcode)) begin
                r_nzcv[0] <= r_alu_flags[0];
            end
        end
    end

    // Registered handshake, ALU-control and completion outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_ready     <= 1'b1;
            r_alu_enable      <= 1'b0;
            r_alu_opcode      <= 4'b0000;
            r_alu_carry_in    <= 1'b0;
            r_alu_flag_update <= 1'b0;
            r_done_valid      <= 1'b0;
            r_done_executed   <= 1'b0;
        end else begin
            r_instr_ready     <= (w_state_nxt == S_IDLE);
            r_alu_enable      <= (w_state_nxt == S_EXEC);
            r_alu_opcode      <= (w_state_nxt == S_EXEC) ? r_opcode : 4'b0000;
            r_alu_carry_in    <= (w_state_nxt == S_EXEC) ? r_nzcv[1] : 1'b0;
            r_alu_flag_update <= (w_state_nxt == S_EXEC) ? w_flag_update : 1'b0;
            r_done_valid      <= (w_state_nxt == S_WB);
            r_done_executed   <= (w_state_nxt == S_WB) && (r_state == S_EXEC);
        end
    end

    assign bus.instr_ready     = r_instr_ready;
    assign bus.alu_enable      = r_alu_enable;
    assign bus.alu_opcode      = r_alu_opcode;
    assign bus.alu_operand1    = r_op1;
    assign bus.alu_operand2    = r_op2;
    assign bus.alu_carry_in    = r_alu_carry_in;
    assign bus.alu_flag_update = r_alu_flag_update;
    assign bus.done_valid      = r_done_valid;
    assign bus.done_executed   = r_done_executed;
    assign bus.nzcv            = r_nzcv;
    assign bus.dbg_data        = r_regs[bus.dbg_addr];

endmodule
